// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
// Shared sizes, types and helpers for the HUB75 column feeder.
//   - Panel geometry (NUM_COLS, NUM_ROWS, SCAN_RATE), pixel depth (RGB_RES),
//     slice index width (THETA_RES) and frame buffer read latency (MEM_LATENCY).
//   - pixel_t / line_t / row_pair_t describe the two half-panel lines
//     presented to the output driver.
//   - feeder_state_t is the feeder control state.
//   - make_addr() builds the frame buffer read address {slice, row, col}.
// ---------------------------------------------------------------------------
package hub75_pkg;

    localparam int NUM_COLS    = 64;
    localparam int NUM_ROWS    = 64;
    localparam int SCAN_RATE   = 32;
    localparam int RGB_RES     = 9;
    localparam int THETA_RES   = 8;
    localparam int MEM_LATENCY = 2;

    localparam int COL_W  = $clog2(NUM_COLS);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int SCAN_W = $clog2(SCAN_RATE);
    // Fetch index covers both halves: one extra bit above the column.
    localparam int K_W    = COL_W + 1;
    localparam int ADDR_W = THETA_RES + ROW_W + COL_W;
    localparam int TAG_W  = 1 + COL_W;

    typedef logic [RGB_RES-1:0]   pixel_t;
    typedef pixel_t [NUM_COLS-1:0] line_t;
    typedef line_t [1:0]           row_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_VALID
    } feeder_state_t;

    // Destination of an in-flight read: which half-line and which column.
    typedef struct packed {
        logic             half;
        logic [COL_W-1:0] col;
    } cap_tag_t;

    // Upper half uses row a, lower half row a+SCAN_RATE. a < SCAN_RATE, so
    // the sum always fits in ROW_W bits.
    function automatic logic [ADDR_W-1:0] make_addr(
        input logic [THETA_RES-1:0] slice,
        input logic [SCAN_W-1:0]    a,
        input logic [K_W-1:0]       k
    );
        logic [ROW_W-1:0] row;
        row = ROW_W'(a) + (k[COL_W] ? ROW_W'(SCAN_RATE) : ROW_W'(0));
        return {slice, row, k[COL_W-1:0]};
    endfunction

endpackage

// File: rtl/hub75_column_feeder_if.sv
// ---------------------------------------------------------------------------
// hub75_column_feeder_if
// Bus bundle between the column feeder, the slice frame buffer read port and
// the HUB75 output driver.
//   mem_addr     feeder -> memory   read address {slice,row,col}
//   mem_ren      feeder -> memory   read strobe
//   mem_rdata    memory -> feeder   read data, MEM_LATENCY cycles after mem_ren
//   column_data  feeder -> driver   [0]=row a, [1]=row a+SCAN_RATE
//   address_data feeder -> driver   scan address a of column_data
//   tvalid       feeder -> driver   column_data/address_data valid
//   tready       driver -> feeder   transfer when tvalid && tready
// master = feeder side, slave = memory/driver side.
// ---------------------------------------------------------------------------
interface hub75_column_feeder_if;
    import hub75_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    pixel_t            mem_rdata;
    row_pair_t         column_data;
    logic [SCAN_W-1:0] address_data;
    logic              tvalid;
    logic              tready;

    modport master (
        output mem_addr, mem_ren, column_data, address_data, tvalid,
        input  mem_rdata, tready
    );

    modport slave (
        input  mem_addr, mem_ren, column_data, address_data, tvalid,
        output mem_rdata, tready
    );

endinterface

// File: rtl/hub75_column_feeder_pipe.sv
// ---------------------------------------------------------------------------
// mem_latency_pipe
// Valid/tag delay line matching the frame buffer read latency: a read issued
// in cycle c appears on valid_o/tag_o in cycle c+DEPTH, aligned with its data.
//   clk_in   clock
//   rst_in   synchronous active-high reset, flushes in-flight entries
//   valid_i  read issued this cycle
//   tag_i    destination tag of that read
//   valid_o  delayed valid
//   tag_o    delayed tag
// ---------------------------------------------------------------------------
module mem_latency_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 7
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;

    // NOTE: sequential state uses <= so every stage reads the pre-edge value
    // of its neighbour; with = the whole line would collapse into one stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q[0] <= valid_i;
            tag_q[0]   <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign tag_o   = tag_q[DEPTH-1];

endmodule

// File: rtl/hub75_column_feeder.sv
// ---------------------------------------------------------------------------
// hub75_column_feeder
// Producer end of the HUB75 row stream. For each scan address a it reads
// 2*NUM_COLS pixels of the current slice (row a, then row a+SCAN_RATE) from
// the frame buffer, assembles both lines and offers them with a to the output
// driver over tvalid/tready. Walks all SCAN_RATE addresses per frame and
// samples slice_in only at frame start.
//   clk_in      system clock
//   rst_in      synchronous active-high reset
//   enable      start/continue frames (sampled in IDLE and at frame end)
//   slice_in    rotational slice index
//   bus         master side of hub75_column_feeder_if (memory + driver)
//   frame_done  one-cycle pulse after the last address of a frame is taken
//   busy        high whenever not IDLE
// ---------------------------------------------------------------------------
module hub75_column_feeder
    import hub75_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable,
    input  logic [THETA_RES-1:0]  slice_in,
    hub75_column_feeder_if.master bus,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [K_W-1:0]    K_LAST = K_W'(2 * NUM_COLS - 1);
    localparam logic [SCAN_W-1:0] A_LAST = SCAN_W'(SCAN_RATE - 1);
    localparam logic [COL_W-1:0]  C_LAST = COL_W'(NUM_COLS - 1);

    feeder_state_t        state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [SCAN_W-1:0]    a_q, a_d;
    logic [THETA_RES-1:0] slice_q, slice_d;
    logic                 frame_done_q, frame_done_d;
    row_pair_t            column_q;

    logic                 fetch_active;
    cap_tag_t             fetch_tag;
    logic                 cap_valid;
    cap_tag_t             cap_tag;
    logic                 last_capture;

    assign fetch_active = (state_q == ST_FETCH);
    assign fetch_tag    = '{half: k_q[COL_W], col: k_q[COL_W-1:0]};

    mem_latency_pipe #(
        .DEPTH (MEM_LATENCY),
        .TAG_W (TAG_W)
    ) u_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .valid_i (fetch_active),
        .tag_i   (fetch_tag),
        .valid_o (cap_valid),
        .tag_o   (cap_tag)
    );

    // Reads are issued in k order, so the lower-half last column is the
    // final capture of the row pair.
    assign last_capture = cap_valid && cap_tag.half && (cap_tag.col == C_LAST);

    // ------------------------------------------------------------------
    // Control state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            a_q          <= '0;
            slice_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            a_q          <= a_d;
            slice_q      <= slice_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture: the delayed tag steers mem_rdata into its line slot. The
    // pipe is flushed by reset, so reads in flight at reset never land.
    // ------------------------------------------------------------------
    // NOTE: the line storage is reset on purpose: the driver may observe
    // column_data right after reset and must see zeros, not power-up junk.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            column_q <= '0;
        end else if (cap_valid) begin
            column_q[cap_tag.half][cap_tag.col] <= bus.mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default before the case; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        a_d          = a_q;
        slice_d      = slice_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    slice_d = slice_in;
                    a_d     = '0;
                    k_d     = '0;
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (last_capture) begin
                    state_d = ST_VALID;
                end
            end

            ST_VALID: begin
                if (bus.tready) begin
                    k_d = '0;
                    if (a_q == A_LAST) begin
                        frame_done_d = 1'b1;
                        if (enable) begin
                            slice_d = slice_in;
                            a_d     = '0;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        a_d     = a_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_ren      = fetch_active;
    assign bus.mem_addr     = fetch_active ? make_addr(slice_q, a_q, k_q) : '0;
    assign bus.column_data  = column_q;
    assign bus.address_data = a_q;
    assign bus.tvalid       = (state_q == ST_VALID);
    assign frame_done       = frame_done_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hub75_column_feeder.sv
// ---------------------------------------------------------------------------
// tb_hub75_column_feeder
// Self-checking bench for hub75_column_feeder. A frame buffer model returns
// addr[8:0] ^ addr[17:9] with MEM_LATENCY cycles of delay, so every pixel
// depends on slice, row and column.
// ---------------------------------------------------------------------------
module tb_hub75_column_feeder;
    import hub75_pkg::*;

    typedef struct {
        logic   half;
        int     col;
        pixel_t exp;
    } pix_vec_t;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 enable;
    logic [THETA_RES-1:0] slice_in;
    logic                 frame_done;
    logic                 busy;

    hub75_column_feeder_if bus();

    hub75_column_feeder dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .enable     (enable),
        .slice_in   (slice_in),
        .bus        (bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- frame buffer model ----------------
    function automatic pixel_t model(input logic [ADDR_W-1:0] addr);
        return addr[8:0] ^ addr[17:9];
    endfunction

    function automatic pixel_t pix(input logic [THETA_RES-1:0] s,
                                   input logic [ROW_W-1:0] r,
                                   input logic [COL_W-1:0] c);
        return model({s, r, c});
    endfunction

    pixel_t rd_pipe [MEM_LATENCY];

    always @(posedge clk_in) begin
        rd_pipe[0] <= model(bus.mem_addr);
        for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bus.mem_rdata = rd_pipe[MEM_LATENCY-1];

    // ---------------- monitors ----------------
    int                   checks = 0;
    int                   errors = 0;
    int                   ren_total = 0;
    int                   fd_cnt = 0;
    int                   frame_idx = 0;
    int                   slice_err = 0;
    logic [THETA_RES-1:0] exp_slice [4];
    int                   xfer_q [$];

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (frame_done) begin
                fd_cnt++;
                frame_idx++;
            end
            if (bus.mem_ren) begin
                ren_total++;
                if (bus.mem_addr[ADDR_W-1 -: THETA_RES] != exp_slice[frame_idx]) slice_err++;
            end
            if (bus.tvalid && bus.tready) xfer_q.push_back(int'(bus.address_data));
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pix_vec_t vecs [8];
        int t_fetch;
        int t_last;
        int t_valid;
        int n_ren;
        int ren0;
        int cols [3];

        // Hand-computed for slice 5, a=0: upper = col ^ 40, lower = col ^ 44.
        vecs[0] = '{half: 1'b0, col: 0,  exp: 9'd40};
        vecs[1] = '{half: 1'b0, col: 3,  exp: 9'd43};
        vecs[2] = '{half: 1'b0, col: 17, exp: 9'd57};
        vecs[3] = '{half: 1'b0, col: 63, exp: 9'd23};
        vecs[4] = '{half: 1'b1, col: 0,  exp: 9'd44};
        vecs[5] = '{half: 1'b1, col: 3,  exp: 9'd47};
        vecs[6] = '{half: 1'b1, col: 40, exp: 9'd4};
        vecs[7] = '{half: 1'b1, col: 63, exp: 9'd19};
        cols[0] = 0; cols[1] = 21; cols[2] = 63;

        exp_slice[0] = 8'd5;
        exp_slice[1] = 8'd6;
        exp_slice[2] = 8'd9;
        exp_slice[3] = 8'd0;

        rst_in     = 1'b1;
        enable     = 1'b0;
        slice_in   = '0;
        bus.tready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_tvalid", bus.tvalid, 0);
        check("rst_mem_ren", bus.mem_ren, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_column_zero", bus.column_data == '0, 1);
        check("rst_address", bus.address_data, 0);
        check("rst_mem_addr", bus.mem_addr, 0);

        // Single row: fetch timing and line placement
        rst_in   = 1'b0;
        slice_in = 8'd5;
        enable   = 1'b1;
        t_fetch = -1; t_last = -1; t_valid = -1; n_ren = 0;
        for (int i = 0; i < 400 && t_valid < 0; i++) begin
            tick();
            if (bus.mem_ren) begin
                if (t_fetch < 0) t_fetch = i;
                t_last = i;
                n_ren++;
            end
            if (bus.tvalid) t_valid = i;
        end
        check("tvalid_latency", t_valid - t_fetch, 130);
        check("ren_count", n_ren, 128);
        check("ren_contiguous", t_last - t_fetch + 1, 128);
        check("busy_valid", busy, 1);
        check("addr_row0", bus.address_data, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("pix_row0_h%0d_c%0d", vecs[i].half, vecs[i].col),
                  bus.column_data[vecs[i].half][vecs[i].col], vecs[i].exp);

        // Backpressure: everything frozen, no reads
        ren0 = ren_total;
        repeat (50) tick();
        check("hold_tvalid", bus.tvalid, 1);
        check("hold_addr", bus.address_data, 0);
        check("hold_no_ren", ren_total - ren0, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("pix_hold_h%0d_c%0d", vecs[i].half, vecs[i].col),
                  bus.column_data[vecs[i].half][vecs[i].col], vecs[i].exp);

        // One-cycle tready pulse
        bus.tready = 1'b1;
        tick();
        bus.tready = 1'b0;
        check("tvalid_drop", bus.tvalid, 0);
        check("busy_refetch", busy, 1);
        for (int i = 0; i < 200 && !bus.tvalid; i++) tick();
        check("row1_tvalid", bus.tvalid, 1);
        check("addr_row1", bus.address_data, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pix_row1_c%0d", cols[i]), bus.column_data[0][cols[i]],
                  pix(8'd5, 6'd1, COL_W'(cols[i])));
            check($sformatf("pix_row33_c%0d", cols[i]), bus.column_data[1][cols[i]],
                  pix(8'd5, 6'd33, COL_W'(cols[i])));
        end

        // Finish frame 0 with the driver always ready; slice_in change unused
        slice_in   = 8'd6;
        bus.tready = 1'b1;
        for (int i = 0; i < 5000 && fd_cnt < 1; i++) tick();
        check("frame0_done", fd_cnt, 1);
        check("frame0_xfers", xfer_q.size(), 32);
        xfer_q.delete();

        // Full frame 1 on slice 6; slice 9 arrives mid-frame
        for (int i = 0; i < 2000 && xfer_q.size() < 5; i++) tick();
        slice_in = 8'd9;
        for (int i = 0; i < 5000 && fd_cnt < 2; i++) tick();
        check("frame1_done", fd_cnt, 2);
        check("frame_done_pulse", frame_done, 0);
        check("frame1_xfers", xfer_q.size(), 32);
        for (int i = 0; i < 32 && i < xfer_q.size(); i++)
            check($sformatf("frame1_addr%0d", i), xfer_q[i], i);

        // Reset mid-fetch at k=40 of frame 2
        repeat (39) tick();
        check("k40_ren", bus.mem_ren, 1);
        check("k40_col", bus.mem_addr[COL_W-1:0], 40);
        check("k40_slice", bus.mem_addr[ADDR_W-1 -: THETA_RES], 9);
        enable = 1'b0;
        rst_in = 1'b1;
        tick();
        check("midrst_ren", bus.mem_ren, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tvalid", bus.tvalid, 0);
        check("midrst_column_zero", bus.column_data == '0, 1);
        rst_in = 1'b0;
        repeat (6) tick();
        check("no_stale_capture", bus.column_data == '0, 1);
        check("idle_after_rst", busy, 0);
        check("slice_sampling", slice_err, 0);

        // Enable dropped at address 10: frame still runs to 31
        exp_slice[2] = 8'd3;
        slice_in     = 8'd3;
        xfer_q.delete();
        enable = 1'b1;
        for (int i = 0; i < 3000 && !(bus.tvalid && bus.address_data == 5'd10); i++) tick();
        check("reach_addr10", bus.address_data, 10);
        enable = 1'b0;
        for (int i = 0; i < 5000 && fd_cnt < 3; i++) tick();
        check("drop_frame_done", fd_cnt, 3);
        check("drop_xfers", xfer_q.size(), 32);
        if (xfer_q.size() > 0) check("drop_last_addr", xfer_q[$], 31);
        tick();
        check("drop_busy", busy, 0);
        ren0 = ren_total;
        repeat (200) tick();
        check("drop_no_ren", ren_total - ren0, 0);
        check("drop_idle_busy", busy, 0);
        check("drop_idle_tvalid", bus.tvalid, 0);
        check("drop_fd_count", fd_cnt, 3);
        check("slice_sampling_final", slice_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
